// File: rtl/bbc_mailbox_target.sv
// BBC-side mailbox responder: 4-byte FRED window over tx/rx byte FIFOs, phi0 synchronised onto hsclk.
// Optional MAILBOX_IRQ_EN adds a CTRL.IRQ_EN bit driving bbc_irq on tx not empty.
module bbc_mailbox_target #(
  parameter logic [15:0] BASE_ADDR   = 16'hFCA0,
  parameter int          FIFO_AW     = 2,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        hsclk,
  input  logic        rst,
  input  logic        bbc_ck2_phi0,
  input  logic [15:0] bbc_addr,
  input  logic        bbc_rnw,
  input  logic [7:0]  bbc_data_in,
  output logic [7:0]  bbc_data_out,
  output logic        bbc_data_oe,
  output logic        bbc_irq,
  input  logic [7:0]  tx_wdata,
  input  logic        tx_wr,
  output logic        tx_full,
  output logic [7:0]  rx_rdata,
  input  logic        rx_rd,
  output logic        rx_empty
);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, ACTIVE, SKIP} state_t;
  state_t state, state_nxt;

  // Bus signals ride the same pipeline depth as phi0 so they stay aligned with the edges.
  logic [SYNC_STAGES-1:0]       phi_pipe;
  logic [SYNC_STAGES-1:0]       rnw_pipe;
  logic [SYNC_STAGES-1:0][15:0] addr_pipe;
  logic [SYNC_STAGES-1:0][7:0]  data_pipe;
  logic                         phi_d;

  always_ff @(posedge hsclk or posedge rst)
    if (rst) begin
      phi_pipe  <= '1;
      phi_d     <= 1'b1;
      rnw_pipe  <= '0;
      addr_pipe <= '0;
      data_pipe <= '0;
    end else begin
      phi_pipe  <= {phi_pipe[SYNC_STAGES-2:0], bbc_ck2_phi0};
      phi_d     <= phi_pipe[SYNC_STAGES-1];
      rnw_pipe  <= {rnw_pipe[SYNC_STAGES-2:0], bbc_rnw};
      addr_pipe <= {addr_pipe[SYNC_STAGES-2:0], bbc_addr};
      data_pipe <= {data_pipe[SYNC_STAGES-2:0], bbc_data_in};
    end

  logic        phi_s, rise, fall, rnw_s, sel;
  logic [15:0] addr_s;
  logic [7:0]  data_s;
  assign phi_s  = phi_pipe[SYNC_STAGES-1];
  assign rnw_s  = rnw_pipe[SYNC_STAGES-1];
  assign addr_s = addr_pipe[SYNC_STAGES-1];
  assign data_s = data_pipe[SYNC_STAGES-1];
  assign rise   = phi_s & ~phi_d;
  assign fall   = ~phi_s & phi_d;
  assign sel    = (addr_s[15:2] == BASE_ADDR[15:2]);

  always_ff @(posedge hsclk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (rise) state_nxt = sel ? ACTIVE : SKIP;
      ACTIVE, SKIP: if (fall) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  logic       start, commit;
  logic [1:0] off_l;
  logic       rnw_l, tx_empty_l;
  assign start  = (state == IDLE) & rise & sel;
  assign commit = (state == ACTIVE) & fall;

  // FIFO storage and pointers
  logic [DEPTH-1:0][7:0] tx_mem, rx_mem;
  logic [FIFO_AW:0]      tx_wp, tx_rp, rx_wp, rx_rp;
  logic                  tx_empty, tx_full_i, rx_empty_i, rx_full_i;
  logic                  tx_push, tx_pop, rx_push, rx_pop;
  logic                  rd_data_hit, wr_data_hit, wr_stat_hit;
  logic                  under, over;
  logic [7:0]            tx_head, rd_mux;

  assign tx_empty   = (tx_wp == tx_rp);
  assign tx_full_i  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                      (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
  assign rx_empty_i = (rx_wp == rx_rp);
  assign rx_full_i  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                      (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);

  assign rd_data_hit = commit & rnw_l & (off_l == 2'd0);
  assign wr_data_hit = commit & ~rnw_l & (off_l == 2'd0);
  assign wr_stat_hit = commit & ~rnw_l & (off_l == 2'd1);

  // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
  assign tx_pop  = rd_data_hit & ~tx_empty_l;
  assign tx_push = tx_wr & (~tx_full_i | tx_pop);
  assign rx_pop  = rx_rd & ~rx_empty_i;
  assign rx_push = wr_data_hit & (~rx_full_i | rx_pop);

  assign tx_head  = tx_empty ? 8'h00 : tx_mem[tx_rp[FIFO_AW-1:0]];
  assign rx_rdata = rx_empty_i ? 8'h00 : rx_mem[rx_rp[FIFO_AW-1:0]];
  assign rx_empty = rx_empty_i;
  assign tx_full  = tx_full_i;

  always_ff @(posedge hsclk) begin
    if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= tx_wdata;
    if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= data_s;
  end

  always_ff @(posedge hsclk or posedge rst)
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
    end

  always_ff @(posedge hsclk or posedge rst)
    if (rst) begin
      under <= 1'b0;
      over  <= 1'b0;
    end else begin
      if (rd_data_hit & tx_empty_l)      under <= 1'b1;
      else if (wr_stat_hit & data_s[3])  under <= 1'b0;
      if (wr_data_hit & ~rx_push)        over  <= 1'b1;
      else if (wr_stat_hit & data_s[2])  over  <= 1'b0;
    end

`ifdef MAILBOX_IRQ_EN
  logic irq_en, irq_q;
  always_ff @(posedge hsclk or posedge rst)
    if (rst) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (commit & ~rnw_l & (off_l == 2'd2)) irq_en <= data_s[0];
      irq_q <= irq_en & ~tx_empty;
    end
  assign bbc_irq = irq_q;
`else
  assign bbc_irq = 1'b0;
`endif

  always_comb begin
    rd_mux = 8'h00;
    case (addr_s[1:0])
      2'd0: rd_mux = tx_head;
      2'd1: rd_mux = {4'b0, under, over, ~rx_full_i, ~tx_empty};
`ifdef MAILBOX_IRQ_EN
      2'd2: rd_mux = {7'b0, irq_en};
`endif
      default: rd_mux = 8'h00;
    endcase
  end

  // Read data and the underflow decision are both frozen at the rise.
  always_ff @(posedge hsclk or posedge rst)
    if (rst) begin
      off_l        <= '0;
      rnw_l        <= 1'b0;
      tx_empty_l   <= 1'b0;
      bbc_data_out <= 8'h00;
    end else if (start) begin
      off_l      <= addr_s[1:0];
      rnw_l      <= rnw_s;
      tx_empty_l <= tx_empty;
      if (rnw_s) bbc_data_out <= rd_mux;
    end

  assign bbc_data_oe = (state == ACTIVE) & rnw_l;
endmodule

// File: tb/tb_bbc_mailbox_target.sv
// Directed bench for bbc_mailbox_target: host bus cycles driven around hsclk, local FIFO side poked directly.
module tb_bbc_mailbox_target;
  logic        hsclk = 1'b0;
  logic        rst = 1'b1;
  logic        bbc_ck2_phi0 = 1'b0;
  logic [15:0] bbc_addr = 16'h0000;
  logic        bbc_rnw = 1'b1;
  logic [7:0]  bbc_data_in = 8'h00;
  logic [7:0]  bbc_data_out;
  logic        bbc_data_oe;
  logic        bbc_irq;
  logic [7:0]  tx_wdata = 8'h00;
  logic        tx_wr = 1'b0;
  logic        tx_full;
  logic [7:0]  rx_rdata;
  logic        rx_rd = 1'b0;
  logic        rx_empty;

  int checks = 0;
  int failures = 0;
  logic [7:0] rd;
  logic       seen;
  int         lat;

  localparam logic [15:0] BASE = 16'hFCA0;

  bbc_mailbox_target dut (
    .hsclk(hsclk), .rst(rst), .bbc_ck2_phi0(bbc_ck2_phi0), .bbc_addr(bbc_addr),
    .bbc_rnw(bbc_rnw), .bbc_data_in(bbc_data_in), .bbc_data_out(bbc_data_out),
    .bbc_data_oe(bbc_data_oe), .bbc_irq(bbc_irq), .tx_wdata(tx_wdata), .tx_wr(tx_wr),
    .tx_full(tx_full), .rx_rdata(rx_rdata), .rx_rd(rx_rd), .rx_empty(rx_empty)
  );

  always #5 hsclk = ~hsclk;

  task automatic bbc_access(input logic [15:0] a, input logic rnw, input logic [7:0] wd,
                            input logic paf, input logic [7:0] pb,
                            output logic [7:0] rdv, output logic sn, output int first);
    rdv = 8'h00; sn = 1'b0; first = 0;
    @(negedge hsclk);
    bbc_addr = a; bbc_rnw = rnw; bbc_data_in = wd; bbc_ck2_phi0 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge hsclk);
      if (bbc_data_oe) begin
        if (!sn) first = i;
        sn = 1'b1; rdv = bbc_data_out;
      end
    end
    bbc_ck2_phi0 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge hsclk);
      if (bbc_data_oe) begin sn = 1'b1; rdv = bbc_data_out; end
      if (paf && i == 2) begin tx_wr = 1'b1; tx_wdata = pb; end
      if (paf && i == 3) tx_wr = 1'b0;
    end
  endtask

  task automatic host_rd(input logic [15:0] a);
    bbc_access(a, 1'b1, 8'h00, 1'b0, 8'h00, rd, seen, lat);
  endtask

  task automatic host_wr(input logic [15:0] a, input logic [7:0] d);
    bbc_access(a, 1'b0, d, 1'b0, 8'h00, rd, seen, lat);
  endtask

  task automatic push_tx(input logic [7:0] b);
    @(negedge hsclk); tx_wr = 1'b1; tx_wdata = b;
    @(negedge hsclk); tx_wr = 1'b0;
  endtask

  task automatic pop_rx();
    @(negedge hsclk); rx_rd = 1'b1;
    @(negedge hsclk); rx_rd = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge hsclk);
    checks++; if (bbc_data_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", bbc_data_oe); end
    checks++; if (bbc_data_out !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", bbc_data_out); end
    checks++; if (bbc_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", bbc_irq); end
    checks++; if (tx_full !== 1'b0) begin failures++; $display("FAIL reset_tx_full got=%b exp=0", tx_full); end
    checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL reset_rx_empty got=%b exp=1", rx_empty); end
    checks++; if (rx_rdata !== 8'h00) begin failures++; $display("FAIL reset_rx_rdata got=%h exp=00", rx_rdata); end
    repeat (3) @(negedge hsclk);
    rst = 1'b0;
    repeat (4) @(negedge hsclk);
  endtask

  task automatic test_tx_read();
    push_tx(8'h5A); push_tx(8'hA5);
    host_rd(BASE + 16'd1);
    checks++; if (rd !== 8'h03 || !seen) begin failures++; $display("FAIL txrd_status1 got=%h oe=%b exp=03", rd, seen); end
    host_rd(BASE);
    checks++; if (rd !== 8'h5A) begin failures++; $display("FAIL txrd_first got=%h exp=5a", rd); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL txrd_latency got=%0d exp=3", lat); end
    host_rd(BASE);
    checks++; if (rd !== 8'hA5) begin failures++; $display("FAIL txrd_second got=%h exp=a5", rd); end
    host_rd(BASE + 16'd1);
    checks++; if (rd !== 8'h02) begin failures++; $display("FAIL txrd_status2 got=%h exp=02", rd); end
  endtask

  task automatic test_rx_write();
    logic [7:0] exp_b;
    host_wr(BASE, 8'h11); host_wr(BASE, 8'h22); host_wr(BASE, 8'h33);
    host_wr(BASE, 8'h44); host_wr(BASE, 8'h55);
    host_rd(BASE + 16'd1);
    checks++; if (rd !== 8'h04) begin failures++; $display("FAIL rxwr_status_over got=%h exp=04", rd); end
    for (int i = 1; i <= 4; i++) begin
      exp_b = 8'(i * 8'h11);
      checks++; if (rx_empty !== 1'b0 || rx_rdata !== exp_b) begin
        failures++; $display("FAIL rxwr_pop%0d got=%h empty=%b exp=%h", i, rx_rdata, rx_empty, exp_b); end
      pop_rx();
    end
    checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL rxwr_drained got=%b exp=1", rx_empty); end
    host_wr(BASE + 16'd1, 8'h04);
    host_rd(BASE + 16'd1);
    checks++; if (rd !== 8'h02) begin failures++; $display("FAIL rxwr_status_clr got=%h exp=02", rd); end
  endtask

  task automatic test_underflow_decode();
    host_rd(BASE);
    checks++; if (rd !== 8'h00 || !seen) begin failures++; $display("FAIL under_data got=%h oe=%b exp=00", rd, seen); end
    host_rd(BASE + 16'd1);
    checks++; if (rd !== 8'h0A) begin failures++; $display("FAIL under_status got=%h exp=0a", rd); end
    host_rd(16'hFCA4);
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL decode_fca4 oe got=%b exp=0", seen); end
    host_rd(16'hFC9F);
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL decode_fc9f oe got=%b exp=0", seen); end
    host_wr(16'hFCA4, 8'h99);
    host_wr(16'hFC9F, 8'h0C);
    checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL decode_wr rx_empty got=%b exp=1", rx_empty); end
    host_rd(BASE + 16'd1);
    checks++; if (rd !== 8'h0A) begin failures++; $display("FAIL decode_status got=%h exp=0a", rd); end
    host_wr(BASE + 16'd1, 8'h08);
    host_rd(BASE + 16'd1);
    checks++; if (rd !== 8'h02) begin failures++; $display("FAIL under_clr got=%h exp=02", rd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [4];
    exp_q = '{8'h02, 8'h03, 8'h04, 8'hEE};
    push_tx(8'h01); push_tx(8'h02); push_tx(8'h03); push_tx(8'h04);
    checks++; if (tx_full !== 1'b1) begin failures++; $display("FAIL b2b_full got=%b exp=1", tx_full); end
    bbc_access(BASE, 1'b1, 8'h00, 1'b1, 8'hEE, rd, seen, lat);
    checks++; if (rd !== 8'h01) begin failures++; $display("FAIL b2b_pop got=%h exp=01", rd); end
    checks++; if (tx_full !== 1'b1) begin failures++; $display("FAIL b2b_still_full got=%b exp=1", tx_full); end
    for (int i = 0; i < 4; i++) begin
      host_rd(BASE);
      checks++; if (rd !== exp_q[i]) begin failures++; $display("FAIL b2b_drain%0d got=%h exp=%h", i, rd, exp_q[i]); end
    end
    host_rd(BASE + 16'd1);
    checks++; if (rd !== 8'h02) begin failures++; $display("FAIL b2b_status got=%h exp=02", rd); end
  endtask

  task automatic test_reset_mid();
    logic oe_any;
    @(negedge hsclk);
    bbc_addr = BASE + 16'd1; bbc_rnw = 1'b1; bbc_ck2_phi0 = 1'b1;
    repeat (5) @(negedge hsclk);
    checks++; if (bbc_data_oe !== 1'b1) begin failures++; $display("FAIL rstmid_oe_before got=%b exp=1", bbc_data_oe); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bbc_data_oe !== 1'b0) begin failures++; $display("FAIL rstmid_oe_async got=%b exp=0", bbc_data_oe); end
    @(negedge hsclk); @(negedge hsclk);
    rst = 1'b0;
    oe_any = 1'b0;
    repeat (6) begin @(negedge hsclk); oe_any |= bbc_data_oe; end
    bbc_ck2_phi0 = 1'b0;
    repeat (6) begin @(negedge hsclk); oe_any |= bbc_data_oe; end
    checks++; if (oe_any !== 1'b0) begin failures++; $display("FAIL rstmid_no_resp got=%b exp=0", oe_any); end
    bbc_addr = BASE; bbc_rnw = 1'b0; bbc_data_in = 8'h66; bbc_ck2_phi0 = 1'b1;
    repeat (4) @(negedge hsclk);
    #2 rst = 1'b1;
    @(negedge hsclk);
    rst = 1'b0;
    repeat (4) @(negedge hsclk);
    bbc_ck2_phi0 = 1'b0;
    repeat (8) @(negedge hsclk);
    checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL rstmid_rx_empty got=%b exp=1", rx_empty); end
    host_rd(BASE + 16'd1);
    checks++; if (rd !== 8'h02 || !seen) begin failures++; $display("FAIL rstmid_resume got=%h oe=%b exp=02", rd, seen); end
  endtask

  task automatic test_irq();
    host_wr(BASE + 16'd2, 8'h01);
    host_rd(BASE + 16'd2);
`ifdef MAILBOX_IRQ_EN
    checks++; if (rd !== 8'h01) begin failures++; $display("FAIL irq_ctrl_rd got=%h exp=01", rd); end
`else
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL irq_ctrl_rd got=%h exp=00", rd); end
`endif
    checks++; if (bbc_irq !== 1'b0) begin failures++; $display("FAIL irq_idle got=%b exp=0", bbc_irq); end
    push_tx(8'h77);
    repeat (2) @(negedge hsclk);
`ifdef MAILBOX_IRQ_EN
    checks++; if (bbc_irq !== 1'b1) begin failures++; $display("FAIL irq_assert got=%b exp=1", bbc_irq); end
`else
    checks++; if (bbc_irq !== 1'b0) begin failures++; $display("FAIL irq_tied got=%b exp=0", bbc_irq); end
`endif
    host_rd(BASE);
    checks++; if (rd !== 8'h77) begin failures++; $display("FAIL irq_data got=%h exp=77", rd); end
    checks++; if (bbc_irq !== 1'b0) begin failures++; $display("FAIL irq_release got=%b exp=0", bbc_irq); end
  endtask

  initial begin
    test_reset();
    test_tx_read();
    test_rx_write();
    test_underflow_decode();
    test_back_to_back();
    test_reset_mid();
    test_irq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
